// File: rtl/dg_pkg.sv
// Shared definitions for the data_gen packet generator: FSM encodings, word field
// offsets and the header/payload formatters also used to rebuild expected words.
package dg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } dg_state_e;

  localparam int SEQ_W_DEF     = 8;
  localparam int LEN_W         = 10;

  localparam int HDR_PORT_LSB  = 28;
  localparam int HDR_DA_LSB    = 24;
  localparam int HDR_PRIOR_LSB = 21;
  localparam int HDR_LEN_LSB   = 11;
  localparam int HDR_SEQ_LSB   = 0;

  localparam int PAY_SEQ_LSB   = 24;
  localparam int PAY_DA_LSB    = 20;
  localparam int PAY_IDX_LSB   = 10;
  localparam int PAY_LEN_LSB   = 0;

  function automatic logic [31:0] f_hdr(input logic [3:0]       port,
                                        input logic [3:0]       da,
                                        input logic [2:0]       prior,
                                        input logic [LEN_W-1:0] len,
                                        input logic [7:0]       seq);
    logic [31:0] w;
    w = '0;
    w[HDR_PORT_LSB  +: 4]     = port;
    w[HDR_DA_LSB    +: 4]     = da;
    w[HDR_PRIOR_LSB +: 3]     = prior;
    w[HDR_LEN_LSB   +: LEN_W] = len;
    w[HDR_SEQ_LSB   +: 8]     = seq;
    return w;
  endfunction

  function automatic logic [31:0] f_pay(input logic [7:0]       seq,
                                        input logic [3:0]       da,
                                        input logic [LEN_W-1:0] idx,
                                        input logic [LEN_W-1:0] len);
    logic [31:0] w;
    w = '0;
    w[PAY_SEQ_LSB +: 8]     = seq;
    w[PAY_DA_LSB  +: 4]     = da;
    w[PAY_IDX_LSB +: LEN_W] = idx;
    w[PAY_LEN_LSB +: LEN_W] = len;
    return w;
  endfunction

endpackage

// File: rtl/dg_pkt_gen.sv
// Packet generator: captures one (da, prior, len) command and streams a header word
// followed by len deterministic payload words on a valid/ready interface.
module dg_pkt_gen
  import dg_pkg::*;
#(
  parameter int         DATA_W  = 32,
  parameter logic [3:0] PORT_ID = 4'd0,
  parameter int         SEQ_W   = SEQ_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        i_da,
  input  logic [2:0]        i_prior,
  input  logic [9:0]        i_len,
  input  logic              i_vld,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_sop,
  output logic              o_eop,
  input  logic              i_ready,
  output logic              o_drop,
  output logic [15:0]       o_pkt_cnt
);

  dg_state_e        r_state;
  dg_state_e        w_state_nxt;
  logic             r_live;
  logic [3:0]       r_da;
  logic [2:0]       r_prior;
  logic [9:0]       r_len;
  logic [9:0]       r_idx;
  logic [SEQ_W-1:0] r_seq;
  logic [15:0]      r_pkt_cnt;

  logic             w_ready;
  logic             w_hs;
  logic             w_capture;
  logic             w_finish;
  logic             w_last_pay;
  logic [31:0]      w_word;
  logic [7:0]       w_seq8;

  // r_live holds o_ready low for the first clock after reset release
  assign w_ready    = (r_state == ST_IDLE) && r_live;
  assign w_capture  = i_vld && w_ready;
  assign w_hs       = o_valid && i_ready;
  assign w_last_pay = (r_idx == r_len);
  assign w_seq8     = 8'(r_seq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_live    <= 1'b0;
      r_seq     <= '0;
      r_pkt_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
      if (w_finish) begin
        r_seq     <= r_seq + SEQ_W'(1);
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
    end
  end

  // Command fields and the payload index only matter while a packet is in flight
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_da    <= i_da;
      r_prior <= i_prior;
      r_len   <= i_len;
    end
    if (w_hs) begin
      if (r_state == ST_HDR) r_idx <= 10'd1;
      else                   r_idx <= r_idx + 10'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_finish    = 1'b0;
    o_valid     = 1'b0;
    o_sop       = 1'b0;
    o_eop       = 1'b0;
    w_word      = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_capture) w_state_nxt = ST_HDR;
      end
      ST_HDR: begin
        o_valid = 1'b1;
        o_sop   = 1'b1;
        o_eop   = (r_len == 10'd0);
        w_word  = f_hdr(PORT_ID, r_da, r_prior, r_len, w_seq8);
        if (w_hs) begin
          if (r_len == 10'd0) begin
            w_finish    = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_PAY;
          end
        end
      end
      ST_PAY: begin
        o_valid = 1'b1;
        o_eop   = w_last_pay;
        w_word  = f_pay(w_seq8, r_da, r_idx, r_len);
        if (w_hs && w_last_pay) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_ready   = w_ready;
  assign o_data    = DATA_W'(w_word);
  assign o_drop    = i_vld && !w_ready && r_live;
  assign o_pkt_cnt = r_pkt_cnt;

endmodule

// File: tb/tb_dg_pkt_gen.sv
// Directed self-checking bench for dg_pkt_gen with hand-derived expected words.
module tb_dg_pkt_gen;

  localparam logic [3:0] PORT = 4'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  i_da = '0;
  logic [2:0]  i_prior = '0;
  logic [9:0]  i_len = '0;
  logic        i_vld = 1'b0;
  logic        i_ready = 1'b1;
  logic        o_ready;
  logic [31:0] o_data;
  logic        o_valid;
  logic        o_sop;
  logic        o_eop;
  logic        o_drop;
  logic [15:0] o_pkt_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_seq  = 0;
  int exp_cnt  = 0;

  dg_pkt_gen #(.DATA_W(32), .PORT_ID(PORT), .SEQ_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_da(i_da), .i_prior(i_prior), .i_len(i_len),
    .i_vld(i_vld), .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid),
    .o_sop(o_sop), .o_eop(o_eop), .i_ready(i_ready), .o_drop(o_drop),
    .o_pkt_cnt(o_pkt_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] e_hdr(input int da, input int pr, input int ln, input int sq);
    return (32'(PORT) << 28) | (32'(da) << 24) | (32'(pr) << 21) | (32'(ln) << 11) | 32'(sq % 256);
  endfunction

  function automatic logic [31:0] e_pay(input int sq, input int da, input int idx, input int ln);
    return (32'(sq % 256) << 24) | (32'(da) << 20) | (32'(idx) << 10) | 32'(ln);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input int da, input int pr, input int ln);
    int t;
    t = 0;
    @(negedge clk);
    while (!o_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready", 32'(o_ready), 32'd1);
    i_da = 4'(da); i_prior = 3'(pr); i_len = 10'(ln); i_vld = 1'b1;
    @(posedge clk); #1;
    i_vld = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [31:0] ed, input bit es, input bit ee, input bit bp);
    int  t;
    bit  done;
    t = 0; done = 0;
    while (!done && t < 100) begin
      @(negedge clk);
      i_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk({tag, "_valid"}, 32'(o_valid), 32'd1);
      chk({tag, "_data"},  o_data, ed);
      chk({tag, "_sop"},   32'(o_sop), 32'(es));
      chk({tag, "_eop"},   32'(o_eop), 32'(ee));
      done = i_ready;
      @(posedge clk); #1;
      t++;
    end
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    i_ready = 1'b1;
  endtask

  task automatic packet(input int da, input int pr, input int ln, input bit bp);
    send_cmd(da, pr, ln);
    recv("hdr", e_hdr(da, pr, ln, exp_seq), 1'b1, ln == 0, bp);
    for (int k = 1; k <= ln; k++)
      recv("pay", e_pay(exp_seq, da, k, ln), 1'b0, k == ln, bp);
    exp_seq = (exp_seq + 1) % 256;
    exp_cnt = exp_cnt + 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_seq = 0;
    exp_cnt = 0;
  endtask

  initial begin
    // T1 reset
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_sop",   32'(o_sop),   32'd0);
    chk("rst_eop",   32'(o_eop),   32'd0);
    chk("rst_data",  o_data,       32'd0);
    chk("rst_drop",  32'(o_drop),  32'd0);
    chk("rst_cnt",   32'(o_pkt_cnt), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready_lo", 32'(o_ready), 32'd0);
    @(negedge clk);
    chk("rel_ready_hi", 32'(o_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("idle_ready_hold", 32'(o_ready), 32'd1);

    // T2 basic, hand-computed words (PORT_ID=3, da=3, prior=2, len=4, seq=0)
    send_cmd(3, 2, 4);
    chk("t2_ready_low", 32'(o_ready), 32'd0);
    recv("t2_hdr", 32'h3340_2000, 1'b1, 1'b0, 1'b0);
    recv("t2_p1",  32'h0030_0404, 1'b0, 1'b0, 1'b0);
    recv("t2_p2",  32'h0030_0804, 1'b0, 1'b0, 1'b0);
    recv("t2_p3",  32'h0030_0C04, 1'b0, 1'b0, 1'b0);
    recv("t2_p4",  32'h0030_1004, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t2_cnt",   32'(o_pkt_cnt), 32'd1);
    chk("t2_ready", 32'(o_ready),   32'd1);
    chk("t2_idle",  32'(o_valid),   32'd0);
    exp_seq = 1; exp_cnt = 1;

    // T3 header-only packet
    packet(7, 5, 0, 1'b0);
    @(negedge clk);
    chk("t3_ready", 32'(o_ready), 32'd1);
    chk("t3_cnt",   32'(o_pkt_cnt), 32'(exp_cnt));

    // T4 random backpressure
    packet(10, 6, 3, 1'b1);
    @(negedge clk);
    chk("t4_cnt", 32'(o_pkt_cnt), 32'(exp_cnt));

    // T5 command strobe during payload is dropped
    send_cmd(5, 1, 8);
    recv("t5_hdr", e_hdr(5, 1, 8, exp_seq), 1'b1, 1'b0, 1'b0);
    recv("t5_p1", e_pay(exp_seq, 5, 1, 8), 1'b0, 1'b0, 1'b0);
    recv("t5_p2", e_pay(exp_seq, 5, 2, 8), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t5_drop_lo", 32'(o_drop), 32'd0);
    i_da = 4'd9; i_prior = 3'd7; i_len = 10'd2; i_vld = 1'b1;
    #1;
    chk("t5_drop_hi", 32'(o_drop), 32'd1);
    chk("t5_p3", o_data, e_pay(exp_seq, 5, 3, 8));
    @(posedge clk); #1 i_vld = 1'b0;
    for (int k = 4; k <= 8; k++)
      recv("t5_pay", e_pay(exp_seq, 5, k, 8), 1'b0, k == 8, 1'b0);
    exp_seq++; exp_cnt++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_no_extra", 32'(o_valid), 32'd0);
      chk("t5_drop_end", 32'(o_drop), 32'd0);
    end
    chk("t5_cnt", 32'(o_pkt_cnt), 32'(exp_cnt));

    // T6 sequence wrap and maximum length from a fresh reset
    do_reset();
    for (int p = 0; p < 257; p++)
      packet(p % 16, p % 8, 1, 1'b0);
    @(negedge clk);
    chk("t6_cnt257", 32'(o_pkt_cnt), 32'd257);
    packet(12, 4, 1023, 1'b0);
    @(negedge clk);
    chk("t6_cnt258", 32'(o_pkt_cnt), 32'd258);

    // Reset in the middle of a payload aborts the packet
    send_cmd(2, 3, 10);
    recv("t6r_hdr", e_hdr(2, 3, 10, exp_seq), 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++)
      recv("t6r_pay", e_pay(exp_seq, 2, k, 10), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_data",  o_data,       32'd0);
    chk("mid_rst_eop",   32'(o_eop),   32'd0);
    chk("mid_rst_ready", 32'(o_ready), 32'd0);
    chk("mid_rst_cnt",   32'(o_pkt_cnt), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    exp_seq = 0; exp_cnt = 0;
    packet(1, 1, 2, 1'b0);
    @(negedge clk);
    chk("post_rst_cnt", 32'(o_pkt_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
